// File: rtl/ahb_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_resp_pkg
//  Description : Shared types and constants for the external-RAM AHB-Lite
//                responder: FSM state encoding, HTRANS/HRESP encodings and
//                a bus-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_resp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DATA = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } statetype;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Number of byte lanes on a data bus of the given width.
    function automatic int bytes_per_beat(input int ahbw);
        return ahbw / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_ram_array.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_ram_array
//  Description : DEPTH_WORDS x AHBW word-organised storage with per-byte
//                write enables and an asynchronous (combinational) read port.
//                Contents are never reset.
//  Ports       : clk        - clock
//                i_wr_en    - write the addressed word this edge
//                i_wr_strb  - byte-lane enables for the write
//                i_addr     - word index (shared by read and write)
//                i_wr_data  - write data
//                o_rd_data  - read data of the addressed word
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_ram_array
    import ahb_resp_pkg::*;
#(
    parameter int AHBW        = 64,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           i_wr_en,
    input  logic [AHBW/8-1:0]              i_wr_strb,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [AHBW-1:0]                i_wr_data,
    output logic [AHBW-1:0]                o_rd_data
);

    localparam int c_lanes = bytes_per_beat(AHBW);

    // One byte-wide array per lane keeps every lane's storage driven from a
    // single process.
    for (genvar g = 0; g < c_lanes; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (i_wr_en && i_wr_strb[g]) begin
                r_mem[i_addr] <= i_wr_data[8*g +: 8];
            end
        end

        assign o_rd_data[8*g +: 8] = r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/ahb_ext_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_ext_ram_responder
//  Description : AHB-Lite subordinate terminating the SoC external-memory
//                port with an on-chip RAM. Programmable wait states per data
//                phase. When EXTRAM_ERRCHK_EN is defined, out-of-range or
//                misaligned accesses get a two-cycle ERROR response; when it
//                is undefined, addresses wrap modulo the RAM size and HRESP
//                is always OKAY.
//  Ports       : clk       - system clock (HCLK)
//                reset     - synchronous active-high reset
//                HSEL      - subordinate select
//                HADDR     - byte address
//                HWRITE    - 1 = write
//                HSIZE     - transfer size
//                HBURST    - unused, each beat is a single transfer
//                HTRANS    - transfer type
//                HWDATA    - write data (data phase)
//                HWSTRB    - byte-lane enables (data phase)
//                HREADY    - bus ready, qualifies address phase
//                HRDATA    - read data
//                HREADYOUT - transfer done
//                HRESP     - 0 = OKAY, 1 = ERROR
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_ext_ram_responder
    import ahb_resp_pkg::*;
#(
    parameter int                 AHBW        = 64,
    parameter int                 PA_BITS     = 56,
    parameter int                 DEPTH_WORDS = 4096,
    parameter logic [PA_BITS-1:0] BASE_ADDR   = 'h8000_0000,
    parameter int                 WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               HSEL,
    input  logic [PA_BITS-1:0] HADDR,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [2:0]         HBURST,
    input  logic [1:0]         HTRANS,
    input  logic [AHBW-1:0]    HWDATA,
    input  logic [AHBW/8-1:0]  HWSTRB,
    input  logic               HREADY,
    output logic [AHBW-1:0]    HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP
);

    localparam int         c_lsb   = $clog2(bytes_per_beat(AHBW));
    localparam int         c_idx_w = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_wait  = 4'(WAIT_STATES);

    statetype             r_state;
    statetype             w_next;
    statetype             w_start;
    logic [c_idx_w-1:0]   r_index;
    logic                 r_write;
    logic [3:0]           r_wait_cnt;
    logic [AHBW-1:0]      r_rdata_hold;
    logic [AHBW-1:0]      w_ram_rdata;
    logic [PA_BITS-1:0]   w_offset;
    logic                 w_accept;
    logic                 w_take;
    logic                 w_err;
    logic                 w_ram_we;
    logic                 w_hreadyout;
    logic                 w_hresp;
    logic                 w_unused;

    // NONSEQ and SEQ both have HTRANS[1] set.
    assign w_accept = HSEL & HREADY & HTRANS[1];
    // New address phases are only taken when no data phase is stalled.
    assign w_take   = w_accept & ((r_state == IDLE) | (r_state == DATA));
    assign w_offset = HADDR - BASE_ADDR;

`ifdef EXTRAM_ERRCHK_EN
    logic       w_out_of_range;
    logic       w_misaligned;
    logic [7:0] w_size_mask;

    // Addresses below BASE_ADDR wrap to a huge offset, so one upper-bit test
    // covers both ends of the window.
    assign w_out_of_range = |w_offset[PA_BITS-1:c_lsb+c_idx_w];
    assign w_size_mask    = 8'((9'd1 << HSIZE) - 9'd1);
    assign w_misaligned   = |(HADDR[c_lsb-1:0] & w_size_mask[c_lsb-1:0]);
    assign w_err          = w_out_of_range | w_misaligned;
    assign w_unused       = ^{HBURST, HTRANS[0], w_offset[c_lsb-1:0], w_size_mask[7:c_lsb]};
`else
    assign w_err    = 1'b0;
    assign w_unused = ^{HBURST, HTRANS[0], HSIZE, w_offset[c_lsb-1:0],
                        w_offset[PA_BITS-1:c_lsb+c_idx_w]};
`endif

    // Error responses bypass the wait-state counter entirely.
    assign w_start = w_err ? ERR1 : ((c_wait == 4'd0) ? DATA : WAIT);

    // Write commits at the edge that closes the data phase; reset on that
    // same edge discards it.
    assign w_ram_we = (r_state == DATA) & r_write & ~reset;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_start;
            WAIT:    if (r_wait_cnt == 4'd1) w_next = DATA;
            DATA:    w_next = w_accept ? w_start : IDLE;
            ERR1:    w_next = ERR2;
            ERR2:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs decode from the state register only, so HREADYOUT never
    // depends combinationally on HREADY.
    always_comb begin
        w_hreadyout = 1'b1;
        w_hresp     = HRESP_OKAY;
        case (r_state)
            WAIT: w_hreadyout = 1'b0;
`ifdef EXTRAM_ERRCHK_EN
            ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = HRESP_ERROR;
            end
            ERR2: w_hresp = HRESP_ERROR;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_write      <= 1'b0;
            r_wait_cnt   <= 4'd0;
            r_rdata_hold <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_index    <= w_offset[c_lsb +: c_idx_w];
                r_write    <= HWRITE;
                r_wait_cnt <= c_wait;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            // Remember the last read beat so HRDATA is stable afterwards.
            if ((r_state == DATA) && !r_write) begin
                r_rdata_hold <= w_ram_rdata;
            end
        end
    end

    ahb_ram_array #(
        .AHBW        (AHBW),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_ram_we),
        .i_wr_strb (HWSTRB),
        .i_addr    (r_index),
        .i_wr_data (HWDATA),
        .o_rd_data (w_ram_rdata)
    );

    assign HRDATA    = ((r_state == DATA) && !r_write) ? w_ram_rdata : r_rdata_hold;
    assign HREADYOUT = w_hreadyout;
    assign HRESP     = w_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_ext_ram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ahb_ext_ram_responder
//  Description : Self-checking bench for ahb_ext_ram_responder. Two instances
//                (zero and three wait states) share one bus; a pipelined
//                AHB manager pushes expected responses into a scoreboard
//                queue, which is popped as each data phase completes.
//                Honours EXTRAM_ERRCHK_EN for the error-response cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_ext_ram_responder;

    localparam int          DEPTH = 4096;
    localparam logic [55:0] BASE  = 56'h8000_0000;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [55:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  strb;
    } cmd_t;

    typedef struct {
        logic        rd;
        logic        err;
        logic [63:0] data;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    int          tgt;
    logic [55:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [63:0] hwdata;
    logic [7:0]  hwstrb;
    logic        sel0, sel3;
    logic [63:0] rd0, rd3;
    logic        ro0, ro3, rs0, rs3;
    logic        obs_ready, obs_resp;
    logic [63:0] obs_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    cmd_t        cmds[$];
    exp_t        sb[$];
    logic [63:0] model [int];

    always #5 clk = ~clk;

    assign sel0      = hsel && (tgt == 0);
    assign sel3      = hsel && (tgt == 1);
    assign obs_ready = (tgt == 1) ? ro3 : ro0;
    assign obs_resp  = (tgt == 1) ? rs3 : rs0;
    assign obs_rdata = (tgt == 1) ? rd3 : rd0;

    ahb_ext_ram_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .HSEL(sel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
        .HWSTRB(hwstrb), .HREADY(ro0), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    ahb_ext_ram_responder #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .HSEL(sel3), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
        .HWSTRB(hwstrb), .HREADY(ro3), .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit exp_err(input logic [55:0] a, input logic [2:0] sz);
`ifdef EXTRAM_ERRCHK_EN
        logic [55:0] off;
        off = a - BASE;
        return (a < BASE) || (off >= 56'(DEPTH * 8)) || ((a % (56'd1 << sz)) != 56'd0);
`else
        return (a === 56'hx) && (sz === 3'hx);
`endif
    endfunction

    function automatic cmd_t mk(input logic s, input logic [1:0] t, input logic w,
                                input logic [55:0] a, input logic [63:0] d, input logic [7:0] st);
        cmd_t c;
        c.sel = s; c.trans = t; c.wr = w; c.addr = a; c.size = 3'd3; c.wdata = d; c.strb = st;
        return c;
    endfunction

    task automatic present(input cmd_t c);
        hsel = c.sel; htrans = c.trans; hwrite = c.wr; haddr = c.addr; hsize = c.size;
    endtask

    task automatic idle_bus();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'd3;
    endtask

    // Builds the expected response for an accepted transfer and updates the
    // reference memory for writes.
    task automatic push_exp(input cmd_t c);
        exp_t        e;
        logic [55:0] off;
        logic [63:0] w;
        int          key;
        off     = c.addr - BASE;
        key     = tgt * DEPTH + int'((off >> 3) % 56'(DEPTH));
        e.rd    = !c.wr;
        e.err   = exp_err(c.addr, c.size);
        e.waits = e.err ? 1 : ((tgt == 1) ? 3 : 0);
        e.data  = '0;
        if (c.wr && !e.err) begin
            w = model.exists(key) ? model[key] : 64'h0;
            for (int l = 0; l < 8; l++) begin
                if (c.strb[l]) w[8*l +: 8] = c.wdata[8*l +: 8];
            end
            model[key] = w;
        end
        if (!c.wr) e.data = model[key];
        sb.push_back(e);
    endtask

    // Pipelined manager: address of the next command overlaps the data phase
    // of the current one; the address is held while HREADY is low.
    task automatic run_cmds();
        cmd_t cur;
        exp_t e;
        bit   addr_valid, dp_valid, rdy;
        int   lowc, guard;
        addr_valid = 0; dp_valid = 0; lowc = 0; guard = 0;
        if (cmds.size() > 0) begin
            cur = cmds.pop_front(); present(cur); addr_valid = 1;
        end
        while ((addr_valid || dp_valid) && guard < 300) begin
            @(negedge clk);
            rdy = obs_ready;
            if (dp_valid) begin
                if (rdy) begin
                    e = sb.pop_front();
                    check("resp", obs_resp, e.err);
                    check("waits", lowc, e.waits);
                    if (e.rd && !e.err) check("rdata", obs_rdata, e.data);
                    lowc = 0;
                end else begin
                    lowc++;
                    check("stall_resp", obs_resp, sb[0].err);
                end
            end else begin
                check("idle_ready", obs_ready, 1);
                check("idle_resp", obs_resp, 0);
            end
            @(posedge clk); #1;
            if (rdy) begin
                dp_valid = 0;
                hwdata   = {$urandom, $urandom};
                hwstrb   = 8'hFF;
                if (addr_valid && cur.sel && cur.trans[1]) begin
                    dp_valid = 1;
                    hwdata   = cur.wdata;
                    hwstrb   = cur.strb;
                    push_exp(cur);
                end
                if (cmds.size() > 0) begin
                    cur = cmds.pop_front(); present(cur); addr_valid = 1;
                end else begin
                    idle_bus(); addr_valid = 0;
                end
            end
            guard++;
        end
        check("timeout", {addr_valid, dp_valid}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tgt = 0; hburst = 3'b000; hwdata = '0; hwstrb = '0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready0", ro0, 1);
        check("rst_resp0", rs0, 0);
        check("rst_rdata0", rd0, 0);
        check("rst_ready3", ro3, 1);
        check("rst_resp3", rs3, 0);
        check("rst_rdata3", rd3, 0);
        @(posedge clk); #1;

        // Zero-wait instance: basic write/read, partial strobes, ignored
        // transfers, wrap or error on out-of-range.
        tgt = 0;
        cmds.push_back(mk(1, 2'b10, 1, BASE + 56'h10, 64'h1122334455667788, 8'hFF));
        cmds.push_back(mk(1, 2'b10, 0, BASE + 56'h10, 64'h0, 8'h00));
        cmds.push_back(mk(1, 2'b10, 1, BASE + 56'h10, 64'hAABBCCDD00000000, 8'hF0));
        cmds.push_back(mk(1, 2'b10, 0, BASE + 56'h10, 64'h0, 8'h00));
        cmds.push_back(mk(1, 2'b10, 1, BASE + 56'h0,  64'h0123456789ABCDEF, 8'hFF));
        cmds.push_back(mk(1, 2'b10, 1, BASE + 56'h8,  64'hCAFEF00D12345678, 8'hFF));
        cmds.push_back(mk(1, 2'b10, 1, BASE + 56'h8,  64'hFFFFFFFFFFFFFFFF, 8'h00));
        cmds.push_back(mk(1, 2'b00, 1, BASE + 56'h8,  64'h0, 8'h00));
        cmds.push_back(mk(1, 2'b01, 1, BASE + 56'h8,  64'h0, 8'h00));
        cmds.push_back(mk(0, 2'b10, 1, BASE + 56'h8,  64'h0, 8'h00));
        cmds.push_back(mk(1, 2'b10, 0, BASE + 56'h8,  64'h0, 8'h00));
        cmds.push_back(mk(1, 2'b10, 0, BASE + 56'(DEPTH * 8), 64'h0, 8'h00));
        cmds.push_back(mk(1, 2'b00, 0, BASE, 64'h0, 8'h00));
`ifdef EXTRAM_ERRCHK_EN
        cmds.push_back(mk(1, 2'b10, 1, BASE + 56'h4, 64'h5555666677778888, 8'hFF));
        cmds.push_back(mk(1, 2'b00, 0, BASE, 64'h0, 8'h00));
        cmds.push_back(mk(1, 2'b10, 0, BASE, 64'h0, 8'h00));
`endif
        run_cmds();

        // Three-wait-state instance: back-to-back pipelined reads.
        tgt = 1;
        cmds.push_back(mk(1, 2'b10, 1, BASE + 56'h0,  64'h0F0E0D0C0B0A0908, 8'hFF));
        cmds.push_back(mk(1, 2'b10, 1, BASE + 56'h8,  64'h1716151413121110, 8'hFF));
        cmds.push_back(mk(1, 2'b10, 1, BASE + 56'h28, 64'h5A5A5A5AA5A5A5A5, 8'hFF));
        cmds.push_back(mk(1, 2'b10, 0, BASE + 56'h0,  64'h0, 8'h00));
        cmds.push_back(mk(1, 2'b10, 0, BASE + 56'h8,  64'h0, 8'h00));
        run_cmds();

        // Reset during the wait phase of a write aborts it.
        @(posedge clk); #1;
        present(mk(1, 2'b10, 1, BASE + 56'h28, 64'h0, 8'h00));
        @(posedge clk); #1;
        idle_bus(); hwdata = 64'hDEADBEEFDEADBEEF; hwstrb = 8'hFF;
        @(negedge clk);
        check("pre_rst_wait", obs_ready, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", obs_ready, 1);
        check("post_rst_resp", obs_resp, 0);
        check("post_rst_rdata", obs_rdata, 0);
        @(posedge clk); #1;
        cmds.push_back(mk(1, 2'b10, 0, BASE + 56'h28, 64'h0, 8'h00));
        run_cmds();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
